// File: rtl/stream_rr_merge.sv
// stream_rr_merge: per-lane round-robin N:1 stream merger with optional skid/output buffering
module stream_rr_merge #(
  parameter int NUM_REQS     = 1,
  parameter int LANES        = 1,
  parameter int DATAW        = 1,
  parameter int BUFFERED     = 0,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS*LANES-1:0]        valid_in,
  input  logic [NUM_REQS*LANES*DATAW-1:0]  data_in,
  output logic [NUM_REQS*LANES-1:0]        ready_in,
  output logic [LANES-1:0]                 valid_out,
  output logic [LANES*DATAW-1:0]           data_out,
  output logic [LANES*LOG_NUM_REQS-1:0]    sel_out,
  input  logic [LANES-1:0]                 ready_out
);
  localparam int LW = LOG_NUM_REQS;
  if (NUM_REQS == 1) begin : g_wire
    assign valid_out = valid_in;
    assign data_out  = data_in;
    assign ready_in  = ready_out;
    assign sel_out   = '0;
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
  end else begin : g_arb
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [NUM_REQS-1:0] req;
      logic [DATAW-1:0] din [NUM_REQS];
      logic [LW-1:0] ptr_q, ptr_d, lock_sel_q, scan, grant;
      logic lock_q, any_valid, acc, fire;
      logic [DATAW-1:0] gdata;
      for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
        assign req[i] = valid_in[i*LANES+j];
        assign din[i] = data_in[(i*LANES+j)*DATAW +: DATAW];
        assign ready_in[i*LANES+j] = fire && grant == LW'(i);
      end
      // second pass overrides: requestors at/after ptr beat the wrapped ones
      always_comb begin
        scan = '0;
        for (int i = NUM_REQS-1; i >= 0; i--) if (req[i] && LW'(i) < ptr_q) scan = LW'(i);
        for (int i = NUM_REQS-1; i >= 0; i--) if (req[i] && LW'(i) >= ptr_q) scan = LW'(i);
      end
      assign grant     = lock_q ? lock_sel_q : scan;
      assign any_valid = lock_q ? req[lock_sel_q] : |req;
      assign gdata     = din[grant];
      assign fire      = any_valid && acc;
      assign ptr_d     = fire ? ((grant == LW'(NUM_REQS-1)) ? '0 : grant + 1'b1) : ptr_q;
      always_ff @(posedge clk)
        if (reset) begin
          ptr_q      <= '0;
          lock_q     <= 1'b0;
          lock_sel_q <= '0;
        end else begin
          ptr_q      <= ptr_d;
          lock_q     <= (BUFFERED == 0) && any_valid && !acc;
          lock_sel_q <= grant;
        end
      if (BUFFERED == 0) begin : g_comb
        assign acc                       = ready_out[j];
        assign valid_out[j]              = any_valid;
        assign data_out[j*DATAW +: DATAW] = gdata;
        assign sel_out[j*LW +: LW]       = grant;
      end else if (BUFFERED == 1) begin : g_skid
        logic out_v_q, skid_v_q, out_fire;
        logic [DATAW-1:0] out_d_q, skid_d_q;
        logic [LW-1:0] out_s_q, skid_s_q;
        assign acc      = !skid_v_q;
        assign out_fire = out_v_q && ready_out[j];
        always_ff @(posedge clk)
          if (reset) begin
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
          end else if (skid_v_q) begin
            if (out_fire) begin
              out_d_q  <= skid_d_q;
              out_s_q  <= skid_s_q;
              skid_v_q <= 1'b0;
            end
          end else if (fire) begin
            if (!out_v_q || out_fire) begin
              out_v_q <= 1'b1;
              out_d_q <= gdata;
              out_s_q <= grant;
            end else begin
              skid_v_q <= 1'b1;
              skid_d_q <= gdata;
              skid_s_q <= grant;
            end
          end else if (out_fire) out_v_q <= 1'b0;
        assign valid_out[j]              = out_v_q;
        assign data_out[j*DATAW +: DATAW] = out_d_q;
        assign sel_out[j*LW +: LW]       = out_s_q;
      end else begin : g_reg
        logic out_v_q;
        logic [DATAW-1:0] out_d_q;
        logic [LW-1:0] out_s_q;
        assign acc = ready_out[j] || !out_v_q;
        always_ff @(posedge clk)
          if (reset) out_v_q <= 1'b0;
          else if (acc) begin
            out_v_q <= any_valid;
            if (any_valid) begin
              out_d_q <= gdata;
              out_s_q <= grant;
            end
          end
        assign valid_out[j]              = out_v_q;
        assign data_out[j*DATAW +: DATAW] = out_d_q;
        assign sel_out[j*LW +: LW]       = out_s_q;
      end
    end
  end
endmodule
